// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: instruction field positions, default load/store
// opcodes, the hard-wired zero register and small decode helpers.
package pipeline_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RD_HI = 26;
    localparam int RD_LO = 22;
    localparam int RS_HI = 21;
    localparam int RS_LO = 17;
    localparam int RT_HI = 16;
    localparam int RT_LO = 12;

    localparam logic [4:0] LW_OP_DEFAULT = 5'b01000;
    localparam logic [4:0] SW_OP_DEFAULT = 5'b00111;
    localparam logic [4:0] REG_ZERO      = 5'd0;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t op;
        reg_idx_t rd;
        reg_idx_t rs;
        reg_idx_t rt;
    } insn_fields_t;

    // A pending destination blocks a source read; r0 is never a real dependency.
    function automatic logic reg_hit(input reg_idx_t entry, input reg_idx_t src);
        return (src != REG_ZERO) && (entry == src);
    endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// Decode-side handshake between the decode stage and the load-use scoreboard.
interface load_use_scoreboard_if #(
    parameter int DEPTH = 4
) ();
    logic                       decode_valid;
    logic [31:0]                decode_insn;
    logic                       issue;
    logic                       load_done;
    logic                       flush;
    logic                       stall;
    logic [$clog2(DEPTH+1)-1:0] pending_count;
    logic                       underflow_err;

    modport master (
        output decode_valid, decode_insn, issue, load_done, flush,
        input  stall, pending_count, underflow_err
    );

    modport slave (
        input  decode_valid, decode_insn, issue, load_done, flush,
        output stall, pending_count, underflow_err
    );
endinterface

// File: rtl/dest_fifo.sv
// In-order FIFO of outstanding load destination registers. Exposes every
// storage slot plus a per-slot valid mask so the owner can compare all of them.
module dest_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  reg_idx_t              din,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output reg_idx_t [DEPTH-1:0]  entries,
    output logic [DEPTH-1:0]      valid
);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0]        count_d, count_q;
    logic [PW-1:0]        rd_ptr_d, rd_ptr_q;
    logic [PW-1:0]        wr_ptr_d, wr_ptr_q;
    reg_idx_t [DEPTH-1:0] mem_d, mem_q;
    logic                 do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign entries = mem_q;
    // A full FIFO still accepts a push when the oldest entry leaves this cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Slot i is live when it lies within count entries of the read pointer.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((i + DEPTH - int'(rd_ptr_q)) % DEPTH) < int'(count_q)) valid[i] = 1'b1;
        end
    end

    // Next-state: flush wins over push and pop.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    // Control state: cleared immediately by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Destination storage: contents only matter under the valid mask.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: tracks outstanding load destinations and stalls
// decode when an instruction reads one of them or the tracker is full.
// Optional feature macro STALL_STATS_EN adds a saturating stall-cycle counter.
module load_use_scoreboard
    import pipeline_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [4:0] LW_OP = LW_OP_DEFAULT,
    parameter logic [4:0] SW_OP = SW_OP_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    load_use_scoreboard_if.slave bus
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);
    localparam int CW = $clog2(DEPTH+1);

    insn_fields_t         f;
    logic                 is_load, uses_rt;
    logic                 hazard, full_block;
    logic                 push, pop;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        count;
    reg_idx_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]     entry_valid;
    logic                 underflow_d, underflow_q;
    logic                 unused_insn_bits;

    assign f.op = bus.decode_insn[OP_HI:OP_LO];
    assign f.rd = bus.decode_insn[RD_HI:RD_LO];
    assign f.rs = bus.decode_insn[RS_HI:RS_LO];
    assign f.rt = bus.decode_insn[RT_HI:RT_LO];
    assign unused_insn_bits = ^bus.decode_insn[RT_LO-1:0];

    // Every op reads rs; a store reads rt only as a base it already has.
    assign is_load = (f.op == LW_OP);
    assign uses_rt = (f.op != SW_OP);

    // Compare decode sources against every live entry, including one popping now.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                if (reg_hit(entries[i], f.rs)) hazard = 1'b1;
                if (uses_rt && reg_hit(entries[i], f.rt)) hazard = 1'b1;
            end
        end
    end

    assign full_block        = is_load & fifo_full & ~bus.load_done;
    assign bus.stall         = bus.decode_valid & (hazard | full_block);
    assign push              = bus.issue & bus.decode_valid & is_load & ~bus.stall;
    assign pop               = bus.load_done & ~fifo_empty;
    assign bus.pending_count = count;
    assign bus.underflow_err = underflow_q;

    dest_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (bus.flush),
        .din     (f.rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count),
        .entries (entries),
        .valid   (entry_valid)
    );

    // Underflow is sticky: a writeback with nothing outstanding latches it.
    always_comb begin
        underflow_d = underflow_q | (bus.load_done & fifo_empty);
    end

    // Underflow flag register, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) underflow_q <= 1'b0;
        else          underflow_q <= underflow_d;
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles_d, stall_cycles_q;

    // Saturating count of stalled cycles; flush does not clear it.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Stall statistics register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) stall_cycles_q <= '0;
        else          stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench for load_use_scoreboard: directed vector table,
// hand-written reset/statistics sequence and a randomized run against a
// queue-based reference model.
module tb_load_use_scoreboard;
    localparam int DEPTH = 4;
    localparam int LW  = 8;
    localparam int SW  = 7;
    localparam int ADD = 1;

    logic clock;
    logic reset_n;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles;
`endif

    load_use_scoreboard_if #(.DEPTH(DEPTH)) bus ();

    load_use_scoreboard #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          v;
        logic [31:0] insn;
        int          iss;
        int          ld;
        int          fl;
        int          st;
        int          cnt;
        int          uf;
    } vec_t;

    vec_t vt[32];
    int   nv = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state.
    logic [4:0] mq[$];
    int         m_uf;
    int         m_sc;

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
        return {op[4:0], rd[4:0], rs[4:0], rt[4:0], 12'h000};
    endfunction

    task automatic add_vec(input int v, input logic [31:0] insn, input int iss, input int ld,
                           input int fl, input int st, input int cnt, input int uf);
        vt[nv] = '{v, insn, iss, ld, fl, st, cnt, uf};
        nv++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input int v, input logic [31:0] insn, input int iss, input int ld, input int fl);
        bus.decode_valid = (v != 0);
        bus.decode_insn  = insn;
        bus.issue        = (iss != 0);
        bus.load_done    = (ld != 0);
        bus.flush        = (fl != 0);
    endtask

    task automatic do_reset();
        apply(1, mk(ADD, 3, 5, 5), 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_stall", 32'(bus.stall), 0);
        chk("reset_count", 32'(bus.pending_count), 0);
        chk("reset_uf", 32'(bus.underflow_err), 0);
`ifdef STALL_STATS_EN
        chk("reset_stall_cycles", stall_cycles, 0);
`endif
        apply(0, 32'h0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        mq.delete();
        m_uf = 0;
        m_sc = 0;
    endtask

    function automatic int model_stall(input int v, input logic [31:0] insn, input int ld);
        logic [4:0] op, rs, rt;
        int hz;
        op = insn[31:27];
        rs = insn[21:17];
        rt = insn[16:12];
        hz = 0;
        if (v == 0) return 0;
        foreach (mq[j]) begin
            if (rs != 0 && mq[j] == rs) hz = 1;
            if (op != 5'(SW) && rt != 0 && mq[j] == rt) hz = 1;
        end
        if (op == 5'(LW) && mq.size() == DEPTH && ld == 0) hz = 1;
        return hz;
    endfunction

    initial begin
        reset_n = 1'b0;
        apply(0, 32'h0, 0, 0, 0);

        // Directed table: expected stall/count/underflow seen before each edge.
        add_vec(1, mk(LW, 5, 0, 0),  1, 0, 0, 0, 0, 0);
        add_vec(1, mk(ADD, 3, 5, 0), 1, 0, 0, 1, 1, 0);
        add_vec(1, mk(ADD, 3, 5, 0), 1, 0, 0, 1, 1, 0);
        add_vec(1, mk(ADD, 3, 5, 0), 1, 1, 0, 1, 1, 0);
        add_vec(1, mk(ADD, 3, 5, 0), 1, 0, 0, 0, 0, 0);
        add_vec(1, mk(LW, 0, 0, 0),  1, 0, 0, 0, 0, 0);
        add_vec(1, mk(ADD, 3, 0, 0), 0, 0, 0, 0, 1, 0);
        add_vec(0, 32'h0,            0, 1, 0, 0, 1, 0);
        add_vec(1, mk(LW, 7, 0, 0),  1, 0, 0, 0, 0, 0);
        add_vec(1, mk(SW, 0, 1, 7),  0, 0, 0, 0, 1, 0);
        add_vec(1, mk(SW, 0, 7, 1),  0, 0, 0, 1, 1, 0);
        add_vec(1, mk(ADD, 3, 2, 7), 0, 0, 0, 1, 1, 0);
        add_vec(0, 32'h0,            0, 1, 0, 0, 1, 0);
        add_vec(1, mk(LW, 1, 0, 0),  1, 0, 0, 0, 0, 0);
        add_vec(1, mk(LW, 2, 0, 0),  1, 0, 0, 0, 1, 0);
        add_vec(1, mk(LW, 3, 0, 0),  1, 0, 0, 0, 2, 0);
        add_vec(1, mk(LW, 4, 0, 0),  1, 0, 0, 0, 3, 0);
        add_vec(1, mk(LW, 9, 0, 0),  0, 0, 0, 1, 4, 0);
        add_vec(1, mk(LW, 9, 0, 0),  1, 1, 0, 0, 4, 0);
        add_vec(0, 32'h0,            0, 0, 0, 0, 4, 0);
        add_vec(1, mk(ADD, 3, 9, 0), 0, 0, 0, 1, 4, 0);
        add_vec(1, mk(ADD, 3, 1, 0), 0, 0, 0, 0, 4, 0);
        add_vec(0, 32'h0,            0, 1, 0, 0, 4, 0);
        add_vec(1, mk(LW, 6, 0, 0),  1, 0, 1, 0, 3, 0);
        add_vec(0, 32'h0,            0, 0, 0, 0, 0, 0);
        add_vec(0, 32'h0,            0, 1, 0, 0, 0, 0);
        add_vec(0, 32'h0,            0, 0, 0, 0, 0, 1);
        add_vec(1, mk(ADD, 3, 6, 0), 0, 0, 0, 0, 0, 1);

        do_reset();

        for (int i = 0; i < nv; i++) begin
            @(negedge clock);
            apply(vt[i].v, vt[i].insn, vt[i].iss, vt[i].ld, vt[i].fl);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall), vt[i].st);
            chk($sformatf("vec%0d_count", i), 32'(bus.pending_count), vt[i].cnt);
            chk($sformatf("vec%0d_uf", i), 32'(bus.underflow_err), vt[i].uf);
        end

        // Sticky underflow, stall statistics, then asynchronous reset mid-stall.
        do_reset();
        @(negedge clock);
        apply(0, 32'h0, 0, 1, 0);
        @(negedge clock);
        apply(1, mk(LW, 5, 0, 0), 1, 0, 0);
        #1;
        chk("seq_uf_set", 32'(bus.underflow_err), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            apply(1, mk(ADD, 3, 5, 0), 1, 0, 0);
            #1;
            chk($sformatf("seq_stall%0d", k), 32'(bus.stall), 1);
        end
        @(posedge clock);
        #1;
        chk("seq_count_before_rst", 32'(bus.pending_count), 1);
        chk("seq_uf_held", 32'(bus.underflow_err), 1);
`ifdef STALL_STATS_EN
        chk("seq_stall_cycles6", stall_cycles, 6);
`endif
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_stall", 32'(bus.stall), 0);
        chk("async_rst_count", 32'(bus.pending_count), 0);
        chk("async_rst_uf", 32'(bus.underflow_err), 0);
`ifdef STALL_STATS_EN
        chk("async_rst_stall_cycles", stall_cycles, 0);
`endif
        @(negedge clock);
        apply(0, 32'h0, 0, 0, 0);
        reset_n = 1'b1;

        // Randomized run against the queue model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int v, op, iss, ld, fl, es;
            logic [31:0] insn;
            @(negedge clock);
            v   = ($urandom_range(0, 99) < 85) ? 1 : 0;
            case ($urandom_range(0, 2))
                0:       op = LW;
                1:       op = SW;
                default: op = ADD;
            endcase
            insn = mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            iss = ($urandom_range(0, 99) < 70) ? 1 : 0;
            ld  = ($urandom_range(0, 99) < 30) ? 1 : 0;
            fl  = ($urandom_range(0, 99) < 3) ? 1 : 0;
            apply(v, insn, iss, ld, fl);
            #1;
            es = model_stall(v, insn, ld);
            chk($sformatf("rand%0d_stall", c), 32'(bus.stall), es);
            chk($sformatf("rand%0d_count", c), 32'(bus.pending_count), mq.size());
            chk($sformatf("rand%0d_uf", c), 32'(bus.underflow_err), m_uf);
`ifdef STALL_STATS_EN
            chk($sformatf("rand%0d_stall_cycles", c), stall_cycles, m_sc);
`endif
            if (es != 0) m_sc++;
            if (ld != 0 && mq.size() == 0) m_uf = 1;
            if (fl != 0) begin
                mq.delete();
            end else begin
                if (ld != 0 && mq.size() > 0) void'(mq.pop_front());
                if (iss != 0 && v != 0 && op == LW && es == 0) mq.push_back(insn[26:22]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_use_scoreboard.md
LOAD_USE_SCOREBOARD -- requirements
Module: load_use_scoreboard

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning maximum outstanding loads tracked (2..16).
REQ-002 SHALL provide parameter LW_OP, default 5'b01000, meaning the load opcode.
REQ-003 SHALL provide parameter SW_OP, default 5'b00111, meaning the store opcode (rs read as data).
REQ-004 SHALL provide port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port reset_n, input, 1, meaning the asynchronous, active-low reset.
REQ-006 SHALL provide port decode_valid, input, 1, meaning decode holds a valid instruction.
REQ-007 SHALL provide port decode_insn, input, 32, meaning the decode instruction: op[31:27], rd[26:22], rs[21:17], rt[16:12].
REQ-008 SHALL provide port issue, input, 1, meaning decode instruction advances to execute this cycle.
REQ-009 SHALL provide port load_done, input, 1, meaning the oldest outstanding load writes back this cycle.
REQ-010 SHALL provide port flush, input, 1, meaning pipeline flush; discard all outstanding loads.
REQ-011 SHALL provide port stall, output, 1, meaning hold decode and fetch.
REQ-012 SHALL provide port pending_count, output, $clog2(DEPTH+1), meaning outstanding load count.
REQ-013 SHALL provide port underflow_err, output, 1, meaning sticky flag for load_done while empty.

Function
REQ-014 SHALL keep an in-order FIFO of DEPTH 5-bit destination registers plus count.
REQ-015 SHALL decode is_load = (op == LW_OP); uses_rs = 1 for every op; uses_rt = (op != SW_OP) — store reads rs as data, rt as base.
REQ-016 SHALL assert stall combinationally when decode_valid and any valid entry equals rt (if uses_rt) or rs (if uses_rs), with register 0 never matching.
REQ-017 SHALL also assert stall when decode_valid, is_load and count == DEPTH and load_done is low.
REQ-018 SHALL push decode rd when issue & decode_valid & is_load & ~stall; issue while stall is ignored.
REQ-019 SHALL pop the oldest entry on load_done when count > 0; load_done with count == 0 sets underflow_err and changes nothing else.
REQ-020 SHALL on simultaneous push and pop keep count unchanged, replacing oldest and appending newest correctly at wrap-around.
REQ-021 SHALL evaluate stall against pre-pop contents: a match on the entry popping this cycle still stalls; stall falls the next cycle.
REQ-022 SHALL on flush clear count and pointers next edge, overriding push and pop in the same cycle; stall computed in that cycle is unaffected.
REQ-023 SHALL allow duplicate destination entries; each must pop before its match clears.
REQ-024 SHALL hold underflow_err until reset_n asserts.

Reset
REQ-025 SHALL on reset_n low immediately clear count, read/write pointers, underflow_err (and stall_cycles); stall reads 0 while entries are invalid.
REQ-026 SHALL discard outstanding loads on reset mid-operation; no state survives.

Configuration
REQ-027 SHALL, with STALL_STATS_EN defined, add output stall_cycles (32 bits) incrementing each cycle stall is 1, saturating at all-ones, cleared on reset and not on flush.
REQ-028 SHALL, with STALL_STATS_EN undefined, omit stall_cycles and its counter entirely; all other behaviour identical.

Structure
REQ-029 SHALL place field positions, default LW_OP/SW_OP and the register-0 constant in shared package pipeline_pkg.
REQ-030 SHALL implement the FIFO storage/pointers as sub-module dest_fifo (push, pop, flush, full, empty, entries vector); comparison logic stays in the top.

Verification
REQ-031 SHALL cover: issue load rd=5; next cycle decode add rs=5 -> stall=1 until load_done, stall=0 cycle after.
REQ-032 SHALL cover: load rd=0 issued, decode reads r0 -> stall=0, pending_count=1.
REQ-033 SHALL cover: store (SW_OP) with rt=7 after load rd=7 -> stall=0; store with rs=7 -> stall=1.
REQ-034 SHALL cover: DEPTH=4 loads outstanding, decode fifth load -> stall=1; same cycle load_done -> stall=0, push and pop, count stays 4.
REQ-035 SHALL cover: 3 outstanding, flush with issue of load -> next cycle count=0, stall=0; load_done on empty -> underflow_err=1 until reset_n low.
REQ-036 SHALL cover: reset_n pulsed low mid-stall asynchronously -> count=0, stall=0 before next edge; with STALL_STATS_EN, 6 stall cycles -> stall_cycles=6.
